// File: rtl/bus_mem_responder.sv
// Bus responder memory: a single-port word memory that serves one request at a
// time, inserts LATENCY wait states, and then completes writes with a one-cycle
// BUS_wready pulse and reads with a BUS_rvalid/BUS_rready handshake. After each
// completion it waits for BUS_valid to drop, so a request that is still held is
// never executed a second time.
module bus_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] BUS_addr,
  input  logic [31:0] BUS_wdata,
  input  logic        BUS_mode,
  input  logic        BUS_valid,
  output logic        BUS_wready,
  output logic [31:0] BUS_rdata,
  output logic        BUS_rvalid,
  input  logic        BUS_rready,
  output logic        BUS_err
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  // RESP is the cycle in which the response registers are loaded, so the
  // response becomes visible one cycle after RESP. HOLD keeps a read response
  // up until it is accepted.
  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RESP,
    HOLD,
    RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            mode_q, mode_d;
  logic            err_q, err_d;
  logic            wready_q, wready_d;
  logic            rvalid_q, rvalid_d;
  logic            rerr_q, rerr_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     mem_rdata_q;
  logic            mem_we;
  logic [31:0]     req_off;
  logic            req_err;
  logic [AW-1:0]   rd_idx;

  // Offset from the base is unsigned, so addresses below BASE_ADDR wrap to a
  // huge offset and land in the out-of-range error case.
  assign req_off = BUS_addr - BASE_ADDR;
  assign req_err = (BUS_addr[1:0] != 2'b00) || (req_off >= SPAN);

  // While idle the RAM is addressed straight from the bus, so that with zero
  // wait states the word is already registered when the response is loaded.
  assign rd_idx = (state_q == IDLE) ? req_off[AW+1:2] : idx_q;

  // Next-state and response logic for the request sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    mode_d   = mode_q;
    err_d    = err_q;
    wready_d = 1'b0;
    rvalid_d = rvalid_q;
    rerr_d   = rerr_q;
    rdata_d  = rdata_q;
    mem_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (BUS_valid) begin
          idx_d   = req_off[AW+1:2];
          wdata_d = BUS_wdata;
          mode_d  = BUS_mode;
          err_d   = req_err;
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP: begin
        rerr_d = err_q;
        if (mode_q) begin
          wready_d = 1'b1;
          mem_we   = !err_q;
          state_d  = RELEASE;
        end else begin
          rvalid_d = 1'b1;
          rdata_d  = err_q ? 32'h0 : mem_rdata_q;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (BUS_rready) begin
          rvalid_d = 1'b0;
          rerr_d   = 1'b0;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        rerr_d = 1'b0;
        if (!BUS_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer and response registers; reset drops any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      wdata_q  <= 32'h0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
      wready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      wready_q <= wready_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
    end
  end

  // Block-RAM style storage: synchronous write, registered read, no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
    mem_rdata_q <= mem[rd_idx];
  end

  assign BUS_wready = wready_q;
  assign BUS_rvalid = rvalid_q;
  assign BUS_err    = rerr_q;
  assign BUS_rdata  = rdata_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: three builds (LATENCY 1, 0 and 15) share the
// bus inputs, and only the build picked by sel sees BUS_valid.
module tb_bus_mem_responder;

  localparam int DEPTH = 1024;
  localparam logic [31:0] LAST = 32'(DEPTH * 4 - 4);

  typedef struct packed {
    logic        tmo;
    logic        err;
    logic [7:0]  lat;
    logic [7:0]  width;
    logic [7:0]  extra;
    logic        stable;
    logic [31:0] rdata;
  } obs_t;

  typedef struct {
    logic        m;
    logic [31:0] a;
    logic [31:0] wd;
    int          hr;
    int          hv;
    obs_t        ex;
  } stim_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mode;
  logic        valid;
  logic        rready;
  logic [1:0]  sel;

  logic        wr_a [3];
  logic        rv_a [3];
  logic        er_a [3];
  logic [31:0] rd_a [3];

  logic        o_wready;
  logic        o_rvalid;
  logic        o_err;
  logic [31:0] o_rdata;

  int   checks;
  int   errors;
  obs_t exp_q [$];

  assign o_wready = wr_a[sel];
  assign o_rvalid = rv_a[sel];
  assign o_err    = er_a[sel];
  assign o_rdata  = rd_a[sel];

  bus_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .BUS_addr(addr), .BUS_wdata(wdata), .BUS_mode(mode),
    .BUS_valid(valid && (sel == 2'd0)), .BUS_wready(wr_a[0]), .BUS_rdata(rd_a[0]),
    .BUS_rvalid(rv_a[0]), .BUS_rready(rready), .BUS_err(er_a[0]));

  bus_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .LATENCY(0)) u_dut_lat0 (
    .clk(clk), .rst_n(rst_n), .BUS_addr(addr), .BUS_wdata(wdata), .BUS_mode(mode),
    .BUS_valid(valid && (sel == 2'd1)), .BUS_wready(wr_a[1]), .BUS_rdata(rd_a[1]),
    .BUS_rvalid(rv_a[1]), .BUS_rready(rready), .BUS_err(er_a[1]));

  bus_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .LATENCY(15)) u_dut_lat15 (
    .clk(clk), .rst_n(rst_n), .BUS_addr(addr), .BUS_wdata(wdata), .BUS_mode(mode),
    .BUS_valid(valid && (sel == 2'd2)), .BUS_wready(wr_a[2]), .BUS_rdata(rd_a[2]),
    .BUS_rvalid(rv_a[2]), .BUS_rready(rready), .BUS_err(er_a[2]));

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a bounded wait is ever bypassed.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Expected observation of a normally completing transaction.
  function automatic obs_t mk(input logic err, input int lat, input int width,
                              input int extra, input logic [31:0] rd);
    obs_t r;
    r.tmo    = 1'b0;
    r.err    = err;
    r.lat    = 8'(lat);
    r.width  = 8'(width);
    r.extra  = 8'(extra);
    r.stable = 1'b1;
    r.rdata  = rd;
    return r;
  endfunction

  // Drives one request and records what the selected build did with it:
  // latency from capture edge, response width, extra responses while valid is
  // still held afterwards, and whether the response stayed steady and cleared.
  task automatic run_txn(input logic m, input logic [31:0] a, input logic [31:0] wd,
                         input int hr, input int hv, output obs_t o);
    int          n;
    logic        got;
    logic [31:0] rd0;
    o = '0;
    o.stable = 1'b1;
    @(negedge clk);
    addr   = a;
    wdata  = wd;
    mode   = m;
    valid  = 1'b1;
    rready = (hr <= 1);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = m ? o_wready : o_rvalid;
    end
    if (!got) begin
      o.tmo  = 1'b1;
      valid  = 1'b0;
      rready = 1'b0;
      @(negedge clk);
      return;
    end
    o.lat   = 8'(n - 1);
    o.err   = o_err;
    rd0     = o_rdata;
    o.rdata = m ? 32'h0 : o_rdata;
    o.width = 8'd1;
    if (!m) begin
      for (int i = 1; i < hr; i++) begin
        @(negedge clk);
        if (o_rvalid) o.width++;
        if (!o_rvalid || o_rdata !== rd0 || o_err !== o.err) o.stable = 1'b0;
      end
    end
    rready = 1'b1;
    @(negedge clk);
    if (m ? o_wready : o_rvalid) o.width++;
    if (o_err !== 1'b0) o.stable = 1'b0;
    if (!m && o_rdata !== rd0) o.stable = 1'b0;
    for (int i = 0; i < hv; i++) begin
      @(negedge clk);
      if (o_wready || o_rvalid) o.extra++;
    end
    valid  = 1'b0;
    rready = 1'b0;
    @(negedge clk);
  endtask

  // Reset values of every build while rst_n is held low.
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({wr_a[k], rv_a[k], er_a[k], rd_a[k]} !== 35'h0) begin
        errors++;
        $display("[TB] FAIL reset[%0d] actual %h required 0", k,
                 {wr_a[k], rv_a[k], er_a[k], rd_a[k]});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Basic write followed by a read of the same word.
  task automatic test_write_read();
    stim_t tbl [$];
    obs_t  o, ex;
    tbl.push_back('{1'b1, 32'h10, 32'hDEAD_BEEF, 0, 0, mk(1'b0, 2, 1, 0, 32'h0)});
    tbl.push_back('{1'b0, 32'h10, 32'h0, 0, 0, mk(1'b0, 2, 1, 0, 32'hDEAD_BEEF)});
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].ex);
      run_txn(tbl[i].m, tbl[i].a, tbl[i].wd, tbl[i].hr, tbl[i].hv, o);
      ex = exp_q.pop_front();
      checks++;
      if (o !== ex) begin
        errors++;
        $display("[TB] FAIL write_read[%0d] actual %h required %h", i, o, ex);
      end
    end
  endtask

  // Read held off for five cycles, then valid kept high after completion.
  task automatic test_backpressure();
    stim_t tbl [$];
    obs_t  o, ex;
    tbl.push_back('{1'b0, 32'h10, 32'h0, 5, 4, mk(1'b0, 2, 5, 0, 32'hDEAD_BEEF)});
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].ex);
      run_txn(tbl[i].m, tbl[i].a, tbl[i].wd, tbl[i].hr, tbl[i].hv, o);
      ex = exp_q.pop_front();
      checks++;
      if (o !== ex) begin
        errors++;
        $display("[TB] FAIL backpressure[%0d] actual %h required %h", i, o, ex);
      end
    end
  endtask

  // Misaligned and out-of-range requests flag errors and leave memory intact.
  task automatic test_errors();
    stim_t tbl [$];
    obs_t  o, ex;
    tbl.push_back('{1'b1, 32'h12, 32'h5555_AAAA, 0, 0, mk(1'b1, 2, 1, 0, 32'h0)});
    tbl.push_back('{1'b0, 32'h10, 32'h0, 0, 0, mk(1'b0, 2, 1, 0, 32'hDEAD_BEEF)});
    tbl.push_back('{1'b0, 32'(DEPTH * 4), 32'h0, 0, 0, mk(1'b1, 2, 1, 0, 32'h0)});
    tbl.push_back('{1'b1, 32'(DEPTH * 4) + 32'h10, 32'h7777_7777, 0, 0, mk(1'b1, 2, 1, 0, 32'h0)});
    tbl.push_back('{1'b0, 32'h10, 32'h0, 0, 0, mk(1'b0, 2, 1, 0, 32'hDEAD_BEEF)});
    tbl.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0, 0, 0, mk(1'b1, 2, 1, 0, 32'h0)});
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].ex);
      run_txn(tbl[i].m, tbl[i].a, tbl[i].wd, tbl[i].hr, tbl[i].hv, o);
      ex = exp_q.pop_front();
      checks++;
      if (o !== ex) begin
        errors++;
        $display("[TB] FAIL errors[%0d] actual %h required %h", i, o, ex);
      end
    end
  endtask

  // A write whose valid stays high for ten cycles runs once; a read follows.
  task automatic test_held_valid();
    stim_t tbl [$];
    obs_t  o, ex;
    tbl.push_back('{1'b1, 32'h14, 32'hA5A5_5A5A, 0, 10, mk(1'b0, 2, 1, 0, 32'h0)});
    tbl.push_back('{1'b0, 32'h14, 32'h0, 0, 0, mk(1'b0, 2, 1, 0, 32'hA5A5_5A5A)});
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].ex);
      run_txn(tbl[i].m, tbl[i].a, tbl[i].wd, tbl[i].hr, tbl[i].hv, o);
      ex = exp_q.pop_front();
      checks++;
      if (o !== ex) begin
        errors++;
        $display("[TB] FAIL held_valid[%0d] actual %h required %h", i, o, ex);
      end
    end
  endtask

  // Zero and maximum wait-state builds at the first and last word.
  task automatic test_latency();
    stim_t tbl [$];
    obs_t  o, ex;
    for (int b = 1; b <= 2; b++) begin
      int          lat;
      logic [31:0] v0, v1;
      lat = (b == 1) ? 1 : 16;
      v0  = (b == 1) ? 32'h1111_0000 : 32'h3333_0000;
      v1  = (b == 1) ? 32'h2222_0FFC : 32'h4444_0FFC;
      sel = 2'(b);
      tbl.delete();
      tbl.push_back('{1'b1, 32'h0, v0, 0, 0, mk(1'b0, lat, 1, 0, 32'h0)});
      tbl.push_back('{1'b1, LAST, v1, 0, 0, mk(1'b0, lat, 1, 0, 32'h0)});
      tbl.push_back('{1'b0, 32'h0, 32'h0, 0, 0, mk(1'b0, lat, 1, 0, v0)});
      tbl.push_back('{1'b0, LAST, 32'h0, 0, 0, mk(1'b0, lat, 1, 0, v1)});
      foreach (tbl[i]) begin
        exp_q.push_back(tbl[i].ex);
        run_txn(tbl[i].m, tbl[i].a, tbl[i].wd, tbl[i].hr, tbl[i].hv, o);
        ex = exp_q.pop_front();
        checks++;
        if (o !== ex) begin
          errors++;
          $display("[TB] FAIL latency_b%0d[%0d] actual %h required %h", b, i, o, ex);
        end
      end
    end
    sel = 2'd0;
  endtask

  // Reset mid-write and mid-read: outputs clear at once and the write is lost.
  task automatic test_async_reset();
    obs_t o, ex;
    int   n;
    exp_q.push_back(mk(1'b0, 2, 1, 0, 32'h0));
    run_txn(1'b1, 32'h20, 32'hCAFE_F00D, 0, 0, o);
    ex = exp_q.pop_front();
    checks++;
    if (o !== ex) begin
      errors++;
      $display("[TB] FAIL arst_prior_write actual %h required %h", o, ex);
    end

    @(negedge clk);
    addr  = 32'h20;
    wdata = 32'h1234_5678;
    mode  = 1'b1;
    valid = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_wready, o_rvalid, o_err, o_rdata} !== 35'h0) begin
      errors++;
      $display("[TB] FAIL arst_wait actual %h required 0",
               {o_wready, o_rvalid, o_err, o_rdata});
    end
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    addr   = 32'h10;
    mode   = 1'b0;
    rready = 1'b0;
    valid  = 1'b1;
    n = 0;
    while (!o_rvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL arst_read_pending actual %b/%h required 1/deadbeef", o_rvalid, o_rdata);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_wready, o_rvalid, o_err, o_rdata} !== 35'h0) begin
      errors++;
      $display("[TB] FAIL arst_hold actual %h required 0",
               {o_wready, o_rvalid, o_err, o_rdata});
    end
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    exp_q.push_back(mk(1'b0, 2, 1, 0, 32'hCAFE_F00D));
    run_txn(1'b0, 32'h20, 32'h0, 0, 0, o);
    ex = exp_q.pop_front();
    checks++;
    if (o !== ex) begin
      errors++;
      $display("[TB] FAIL arst_readback actual %h required %h", o, ex);
    end
  endtask

  // Scenario sequence.
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    valid  = 1'b0;
    mode   = 1'b0;
    addr   = 32'h0;
    wdata  = 32'h0;
    rready = 1'b0;
    sel    = 2'd0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_errors();
    test_held_valid();
    test_latency();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
